// File: rtl/unary_add_ctrl_if.sv
// Command/result handshake bundle of the unary adder controller.
// The master issues commands and consumes results; the slave is the controller.
interface unary_add_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_sum;
  logic       res_ovf;
  logic       res_err;

  modport master (
    output cmd_valid, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_sum, res_ovf, res_err
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_sum, res_ovf, res_err
  );
endinterface

// File: rtl/unary_add_ctrl.sv
// Controller for a unary adder: pulses operands A/B into the adder (READ),
// drains the accumulated count back out (WRITE), then presents the result (DONE).
// Every output is a flop; next-state outputs are derived from state_d so that
// they line up with the state they describe.
module unary_add_ctrl #(
  parameter int TIMEOUT = 258
) (
  input  logic             clk,
  input  logic             rst,
  unary_add_ctrl_if.slave  bus,
  output logic             add_rst_n_o,
  output logic             add_en_o,
  output logic             add_rw_o,
  output logic             add_A_o,
  output logic             add_B_o,
  input  logic             add_dout_i,
  input  logic             add_C_i,
  output logic             busy_o
);

  // Phase cycle counter must reach TIMEOUT-1 in WRITE.
  localparam int             CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;       // index of the current cycle within the phase
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    max_q, max_d;
  logic [8:0]    sum_q, sum_d;       // one spare bit so a stuck drain cannot wrap silently
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          res_valid_q, res_valid_d;
  logic          add_en_q, add_en_d;
  logic          add_rw_q, add_rw_d;
  logic          add_A_q, add_A_d;
  logic          add_B_q, add_B_d;
  logic          busy_q, busy_d;
  logic          add_rst_n_q;
  logic          fire;

  assign fire = bus.cmd_valid & cmd_ready_q;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    max_d   = max_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          max_d   = (bus.cmd_a > bus.cmd_b) ? bus.cmd_a : bus.cmd_b;
          sum_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = (max_d != 8'd0) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        if (add_C_i) ovf_d = 1'b1;
        if (cyc_q == CW'(max_q) - CW'(1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        // The adder's drain output lags by one register, so cycle 0 carries
        // only the final accumulate carry and no drain data.
        if (cyc_q == '0) begin
          if (add_C_i) ovf_d = 1'b1;
        end else if (add_dout_i) begin
          sum_d = sum_q + 9'd1;
        end else begin
          state_d = S_DONE;
        end
        if (state_d == S_WRITE && cyc_q == TO_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (res_valid_q && bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cyc_d       = (state_d == state_q) ? cyc_q + CW'(1) : '0;
    add_en_d    = (state_d == S_READ) || (state_d == S_WRITE);
    add_rw_d    = (state_d == S_WRITE);
    add_A_d     = (state_d == S_READ) && (cyc_d < CW'(a_d));
    add_B_d     = (state_d == S_READ) && (cyc_d < CW'(b_d));
    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    // Flops from rst, so it first rises on the same edge as add_rst_n.
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset also clears the adder for one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      add_en_q    <= 1'b0;
      add_rw_q    <= 1'b0;
      add_A_q     <= 1'b0;
      add_B_q     <= 1'b0;
      busy_q      <= 1'b0;
      add_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      max_q       <= max_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      add_en_q    <= add_en_d;
      add_rw_q    <= add_rw_d;
      add_A_q     <= add_A_d;
      add_B_q     <= add_B_d;
      busy_q      <= busy_d;
      add_rst_n_q <= 1'b1;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_sum   = sum_q[7:0];
  assign bus.res_ovf   = ovf_q;
  assign bus.res_err   = err_q;
  assign add_rst_n_o   = add_rst_n_q;
  assign add_en_o      = add_en_q;
  assign add_rw_o      = add_rw_q;
  assign add_A_o       = add_A_q;
  assign add_B_o       = add_B_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_unary_add_ctrl.sv
// Bench for unary_add_ctrl: behavioural unary adder plus a per-command
// reference computed from a, b with plain arithmetic.
module tb_unary_add_ctrl;
  localparam int TIMEOUT = 258;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unary_add_ctrl_if bus ();
  logic add_rst_n, add_en, add_rw, add_A, add_B, busy;
  logic add_dout = 1'b0;
  logic add_C    = 1'b0;

  unary_add_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .add_rst_n_o (add_rst_n),
    .add_en_o    (add_en),
    .add_rw_o    (add_rw),
    .add_A_o     (add_A),
    .add_B_o     (add_B),
    .add_dout_i  (add_dout),
    .add_C_i     (add_C),
    .busy_o      (busy)
  );

  // Unary adder: counts A/B pulses mod 256 with a one-cycle carry pulse,
  // drains one unit per enabled read cycle; outputs are registered.
  logic [7:0] m_cnt = 8'd0;
  bit         stuck = 1'b0;
  always @(posedge clk) begin
    if (!add_rst_n) begin
      m_cnt    <= 8'd0;
      add_C    <= 1'b0;
      add_dout <= 1'b0;
    end else begin
      add_C <= 1'b0;
      if (add_en && !add_rw) begin
        {add_C, m_cnt} <= {1'b0, m_cnt} + {8'd0, add_A} + {8'd0, add_B};
      end else if (add_en && add_rw) begin
        add_dout <= stuck || (m_cnt != 8'd0);
        if (m_cnt != 8'd0) m_cnt <= m_cnt - 8'd1;
      end
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One command from acceptance to result retirement, checked against the reference.
  task automatic run_op(input int a, input int b, input int hold);
    int mx, s, exp_wr, exp_sum, exp_lat;
    bit exp_ovf, exp_err;
    int n, lat, rd, wr, ab_bad, rdy_bad;
    mx      = (a > b) ? a : b;
    s       = (a + b) % 256;
    exp_ovf = (a + b) > 255;
    exp_err = stuck;
    exp_wr  = stuck ? TIMEOUT : s + 2;
    exp_sum = stuck ? (TIMEOUT - 1) % 256 : s;
    exp_lat = mx + exp_wr + 1;

    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a[7:0];
    bus.cmd_b     = b[7:0];
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;

    lat = 0; rd = 0; wr = 0; ab_bad = 0; rdy_bad = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (bus.res_valid) break;
      if (bus.cmd_ready) rdy_bad++;
      if (add_en && !add_rw) begin
        if (add_A !== (rd < a) || add_B !== (rd < b)) ab_bad++;
        rd++;
      end else if (add_en && add_rw) begin
        if (add_A || add_B) ab_bad++;
        wr++;
      end
    end
    check("latency", lat, exp_lat);
    check("read_len", rd, mx);
    check("write_len", wr, exp_wr);
    check("ab_pattern_errs", ab_bad, 0);
    check("cmd_ready_while_busy", rdy_bad, 0);
    check("res_valid", bus.res_valid, 1);
    check("res_sum", bus.res_sum, exp_sum);
    check("res_ovf", bus.res_ovf, exp_ovf);
    check("res_err", bus.res_err, exp_err);
    check("done_add_en", add_en, 0);
    check("done_busy", busy, 1);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_sum", bus.res_sum, exp_sum);
      check("hold_ovf", bus.res_ovf, exp_ovf);
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end

    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check("exit_res_valid", bus.res_valid, 0);
    check("exit_cmd_ready", bus.cmd_ready, 1);
    check("exit_busy", busy, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'd0;
    bus.cmd_b     = 8'd0;
    bus.res_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_add_rst_n", add_rst_n, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_add_en", add_en, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_add_rst_n", add_rst_n, 1);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Directed cases.
    run_op(3, 5, 0);
    run_op(0, 0, 1);
    run_op(200, 100, 2);
    run_op(255, 1, 0);
    run_op(3, 5, 10);

    // Reset in READ cycle 2 of a=10, b=10.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 8'd10;
    bus.cmd_b     = 8'd10;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_read_add_en", add_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_add_rst_n", add_rst_n, 0);
    check("midrst_outputs", {bus.cmd_ready, add_en, add_rw, add_A, add_B,
                             bus.res_valid, bus.res_sum, bus.res_ovf, bus.res_err, busy}, 0);
    @(negedge clk);
    check("midrst_add_rst_n_back", add_rst_n, 1);
    run_op(4, 4, 0);

    // Drain stuck at 1: timeout abort.
    stuck = 1'b1;
    run_op(2, 3, 1);
    stuck = 1'b0;
    run_op(7, 2, 0);

    // Randomized commands, mixing small and full-range operands.
    for (int i = 0; i < 16; i++) begin
      int ra, rb;
      if (i % 2 == 0) begin
        ra = $urandom_range(0, 15);
        rb = $urandom_range(0, 15);
      end else begin
        ra = $urandom_range(0, 255);
        rb = $urandom_range(0, 255);
      end
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/unary_add_ctrl.md
UNARY_ADD_CTRL -- requirements
Module: unary_add_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 258; maximum WRITE-state cycles before the operation is aborted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller accepts a command; high only in IDLE with add_rst_n=1.
REQ-006 cmd_a  input  8  unary length of operand A; sampled on acceptance.
REQ-007 cmd_b  input  8  unary length of operand B; sampled on acceptance.
REQ-008 add_rst_n  output  1  active-low reset to the unary adder.
REQ-009 add_en  output  1  adder enable.
REQ-010 add_rw  output  1  adder phase: 0 = accumulate, 1 = drain.
REQ-011 add_A  output  1  unary pulse, operand A.
REQ-012 add_B  output  1  unary pulse, operand B.
REQ-013 add_dout  input  1  adder drain stream, registered in the adder.
REQ-014 add_C  input  1  adder carry flag, registered in the adder.
REQ-015 res_valid  output  1  result available; held until taken.
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 res_sum  output  8  drained count, (a+b) mod 256.
REQ-018 res_ovf  output  1  carry seen during the operation.
REQ-019 res_err  output  1  drain timeout abort.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 The controller SHALL implement states IDLE, READ, WRITE and DONE.
REQ-022 All outputs SHALL be registered.
REQ-023 Handshake: a command transfers on an edge with cmd_valid=1 and cmd_ready=1, loading a, b and clearing the sum, ovf and err registers.
REQ-024 Transition on acceptance: go to READ when max(a,b) > 0, otherwise go directly to WRITE.
REQ-025 READ phase: exactly max(a,b) consecutive cycles with add_en=1 and add_rw=0.
REQ-026 READ cycle k (k = 0 .. max-1): add_A = (k < a) and add_B = (k < b).
REQ-027 WRITE phase: add_en=1 and add_rw=1, with add_A=0 and add_B=0, in every WRITE cycle.
REQ-028 Carry capture: res_ovf is set if add_C is sampled high in any READ cycle or in the first WRITE cycle; it is sticky until the next command is accepted.
REQ-029 Drain sampling: add_dout is not sampled in the first WRITE cycle; from the second WRITE cycle onward, each sampled 1 increments the 9-bit sum.
REQ-030 Drain end: the first sampled 0 ends WRITE; in the next cycle add_en=0, state is DONE and res_valid=1.
REQ-031 WRITE length: the WRITE phase SHALL last S+2 cycles, where S = (a+b) mod 256.
REQ-032 Timeout: if WRITE reaches TIMEOUT cycles, the controller enters DONE with res_err=1 and res_sum = the low 8 bits of the sum.
REQ-033 DONE: res_valid, res_sum, res_ovf and res_err are held stable until res_ready=1.
REQ-034 DONE exit: on an edge with res_valid=1 and res_ready=1, go to IDLE with res_valid=0.
REQ-035 cmd_ready SHALL be 0 in READ, WRITE and DONE; no new command is accepted while a result is pending.
REQ-036 Adder control outputs: add_en, add_A, add_B and add_rw are 0 in IDLE and DONE.
REQ-037 Latency: from command acceptance to res_valid is max(a,b) + S + 3 cycles.

Reset
REQ-038 When rst=1 at an edge: state=IDLE; outputs cmd_ready, add_en, add_rw, add_A, add_B, res_valid, res_sum, res_ovf, res_err and busy = 0.
REQ-039 add_rst_n is registered from ~rst: reset value 0, and it returns to 1 one cycle after rst deasserts.
REQ-040 cmd_ready stays 0 while add_rst_n=0, so the adder count is cleared before any new command.
REQ-041 Reset mid-operation (READ, WRITE or DONE) SHALL abandon the operation with no result, leaving no residual adder count for the next command.

Verification
REQ-042 a=3, b=5: READ 5 cycles, add_A=1,1,1,0,0 and add_B=1,1,1,1,1; WRITE 10 cycles; res_sum=8, res_ovf=0, res_err=0.
REQ-043 a=0, b=0: no READ cycles; WRITE 2 cycles; res_sum=0, res_ovf=0; res_valid 3 cycles after acceptance.
REQ-044 a=200, b=100: res_sum=44, res_ovf=1; a=255, b=1: res_sum=0, res_ovf=1, WRITE 2 cycles.
REQ-045 Hold res_ready=0 for 10 cycles in DONE: res_valid, res_sum and res_ovf stable, cmd_ready=0 throughout; after res_ready=1, IDLE and cmd_ready=1 next cycle.
REQ-046 rst=1 for one cycle at READ cycle 2 of a=10, b=10: all outputs 0 next cycle, add_rst_n=0 for one cycle; a following a=4, b=4 gives res_sum=8.
REQ-047 Adder model forcing add_dout stuck at 1: res_err=1 after TIMEOUT WRITE cycles, res_valid=1, controller returns to IDLE on res_ready.
